sram_obi_adapter: RTL and testbench
===================================

// Module: sram_obi_adapter
// PURPOSE
//  Bridges a core-side OBI-style request/response bus onto port 0 (RW) of the sram macro wrapper.
//  Sits directly upstream of sram.
//  Handles byte-address to word-address conversion and range checking.
//  Handles the one-cycle SRAM read latency and response backpressure, using a small response FIFO.
//  One request is accepted per cycle at full throughput.
// PARAMETERS
//  SRAM_ADDR_WIDTH  11           word-address width of the attached sram (2^11 x 32b = 8 KiB)
//  BASE_ADDR        32'h0010_0000  byte base address of the SRAM window; must be window-size aligned
//  RSP_DEPTH        2            response FIFO depth; must be >= 2
// PORTS
//  clk          in   1   sole clock; also drives sram clk0
//  rst          in   1   asynchronous, active-high reset
//  req_i        in   1   request valid
//  gnt_o        out  1   request accepted this cycle (req_i && gnt_o)
//  addr_i       in   32  byte address
//  we_i         in   1   1 = write, 0 = read
//  be_i         in   4   byte enables, forwarded as wmask0
//  wdata_i      in   32  write data
//  rvalid_o     out  1   response valid
//  rready_i     in   1   response accepted (rvalid_o && rready_i)
//  rdata_o      out  32  read data; 0 for writes and errors
//  err_o        out  1   address outside the SRAM window
//  sram_csb0_o  out  1   to sram csb0, active low
//  sram_web0_o  out  1   to sram web0
//  sram_wmask0_o out 4   to sram wmask0
//  sram_addr0_o out  SRAM_ADDR_WIDTH  to sram addr0
//  sram_din0_o  out  32  to sram din0
//  sram_dout0_i in   32  from sram dout0
// BEHAVIOUR
//  Reset
//   - Flops: s1_valid = 0, FIFO empty.
//   - Outputs while rst=1: gnt_o = 0, rvalid_o = 0, sram_csb0_o = 1, all other outputs 0.
//   - Reset mid-operation discards all in-flight requests; no responses are produced for them.
//  Address decode
//   - in_range = (addr_i - BASE_ADDR) < 2^(SRAM_ADDR_WIDTH+2).
//   - sram_addr0_o = (addr_i - BASE_ADDR)[SRAM_ADDR_WIDTH+1:2]; addr_i[1:0] is ignored.
//  Credit / grant
//   - credit = RSP_DEPTH - fifo_count - s1_valid + (rvalid_o && rready_i).
//   - gnt_o = req_i && (credit > 0). This is combinational from rready_i (documented path).
//  Issue (combinational, same cycle as the grant)
//   - sram_csb0_o = !(req_i && gnt_o && in_range).
//   - sram_web0_o = !we_i; sram_wmask0_o = be_i; sram_din0_o = wdata_i.
//   - An out-of-range request never touches the SRAM.
//  Stage s1 (registered on grant)
//   - Stores s1_valid, s1_read (= !we_i && in_range) and s1_err (= !in_range).
//   - s1_valid is set only on a grant.
//  Response selection
//   - FIFO non-empty: head of the FIFO is presented.
//   - FIFO empty and s1_valid: s1 response is presented directly (bypass).
//     rdata = s1_read ? sram_dout0_i : 0; err = s1_err.
//   - rvalid_o = fifo_nonempty || s1_valid.
//  FIFO push / pop
//   - s1 is pushed into the FIFO when s1_valid && (fifo_nonempty || !rready_i).
//   - The FIFO is popped on rvalid_o && rready_i when non-empty.
//   - Push and pop in the same cycle keep the count unchanged.
//   - Responses are returned strictly in order.
//  Latency and throughput
//   - Read latency: grant at cycle n -> rvalid_o at n+1 (bypass path).
//   - Throughput is 1 request per cycle when rready_i is held at 1.
//   - The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
//  Writes
//   - Produce a response one cycle later with rdata_o = 0 and err_o = 0.
//   - Write-then-read to the same address in consecutive cycles returns the new data
//     (sram write and read happen in different clock edges).
// STRUCTURE
//  sram_adapter_pkg
//   - typedef struct packed {logic [31:0] rdata; logic err;} sram_rsp_t;
//   - localparam WORD_BYTES = 4.
//  Sub-module sram_rsp_fifo
//   - Parameters: DEPTH, sram_rsp_t entries.
//   - Ports: push/pop, count, head, asynchronous reset.
//   - The adapter instantiates it once and keeps the credit/grant/s1 logic local.
// TESTING
//  1. Reset held, req_i=1 -> gnt_o=0, sram_csb0_o=1, rvalid_o=0.
//     Release reset -> gnt_o=1 in the same cycle.
//  2. Write BASE+0x10, be=4'hF, data 0xDEADBEEF; then read BASE+0x10 with rready=1
//     -> two responses, rvalid at n+1; second has rdata 0xDEADBEEF, err 0.
//  3. Write be=4'b0010, data 0x0000AB00 over 0xDEADBEEF, then read -> 0xDEADABEF.
//  4. Read BASE + 8 KiB -> err_o=1, rdata_o=0, sram_csb0_o stays 1.
//  5. Back-to-back reads of 4 words with rready=0 -> exactly RSP_DEPTH grants, then gnt_o=0.
//     Raise rready -> all 4 responses return in order with correct data.
//  6. Assert reset while 2 responses are pending
//     -> rvalid_o=0 after reset, no stale response emitted.
//     A subsequent read returns correct data.

Source files
------------

// File: rtl/sram_adapter_pkg.sv
// Shared types and constants for the OBI-to-SRAM adapter and its response FIFO.
package sram_adapter_pkg;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } sram_rsp_t;

endpackage

// File: rtl/sram_obi_adapter_if.sv
// Core-side OBI-style request/response bus; the core is master, the adapter is slave.
interface sram_obi_adapter_if;

    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Small in-order response FIFO; head is presented combinationally from storage.
module sram_rsp_fifo
    import sram_adapter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  sram_rsp_t                  din,
    output sram_rsp_t                  head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    sram_rsp_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

    // The upstream credit scheme must make both of these impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
        end
    end

endmodule

// File: rtl/sram_obi_adapter.sv
// Bridges an OBI-style bus onto SRAM port 0, absorbing the one-cycle read latency
// and response backpressure with a credit-limited response FIFO.
module sram_obi_adapter
    import sram_adapter_pkg::*;
#(
    parameter int          SRAM_ADDR_WIDTH = 11,
    parameter logic [31:0] BASE_ADDR       = 32'h0010_0000,
    parameter int          RSP_DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_obi_adapter_if.slave          bus,
    output logic                       sram_csb0_o,
    output logic                       sram_web0_o,
    output logic [3:0]                 sram_wmask0_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [31:0]                sram_din0_o,
    input  logic [31:0]                sram_dout0_i
);

    localparam int LSB = $clog2(WORD_BYTES);
    localparam int CW  = $clog2(RSP_DEPTH + 1);

    logic [31:0]   offset;
    logic          in_range;
    logic          accept;
    logic          rsp_fire;
    logic          fifo_nonempty;
    logic          push;
    logic          pop;
    logic          s1_valid;
    logic          s1_read;
    logic          s1_err;
    logic [CW-1:0] fifo_count;
    int            credit;
    sram_rsp_t     s1_rsp;
    sram_rsp_t     fifo_head;
    sram_rsp_t     rsp;
    logic          unused_addr_lsb;

    assign offset          = bus.addr_i - BASE_ADDR;
    assign in_range        = (offset[31:SRAM_ADDR_WIDTH+LSB] == '0);
    assign unused_addr_lsb = ^offset[LSB-1:0];

    assign fifo_nonempty = (fifo_count != '0);
    assign bus.rvalid_o  = fifo_nonempty || s1_valid;
    assign rsp_fire      = bus.rvalid_o && bus.rready_i;
    assign pop           = rsp_fire && fifo_nonempty;
    // s1 goes straight out when nothing is queued ahead of it and the core is ready.
    assign push          = s1_valid && (fifo_nonempty || !bus.rready_i);

    // A slot freed by this cycle's response handshake can be reused immediately.
    always_comb begin
        credit     = RSP_DEPTH - int'(fifo_count) - int'(s1_valid) + int'(rsp_fire);
        bus.gnt_o  = !rst && bus.req_i && (credit > 0);
    end

    assign accept = bus.req_i && bus.gnt_o;

    always_comb begin
        sram_csb0_o   = !(accept && in_range);
        sram_web0_o   = 1'b0;
        sram_wmask0_o = '0;
        sram_addr0_o  = '0;
        sram_din0_o   = '0;
        if (!rst) begin
            sram_web0_o   = !bus.we_i;
            sram_wmask0_o = bus.be_i;
            sram_addr0_o  = offset[SRAM_ADDR_WIDTH+LSB-1:LSB];
            sram_din0_o   = bus.wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_read  <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_read <= !bus.we_i && in_range;
                s1_err  <= !in_range;
            end
        end
    end

    assign s1_rsp.rdata = s1_read ? sram_dout0_i : 32'h0;
    assign s1_rsp.err   = s1_err;

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (s1_rsp),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign rsp         = fifo_nonempty ? fifo_head : s1_rsp;
    assign bus.rdata_o = bus.rvalid_o ? rsp.rdata : 32'h0;
    assign bus.err_o   = bus.rvalid_o && rsp.err;

endmodule

// File: tb/tb_sram_obi_adapter.sv
// Directed and randomized checks of sram_obi_adapter against a transaction-level model.
module tb_sram_obi_adapter;

    localparam int          AW        = 11;
    localparam logic [31:0] BASE      = 32'h0010_0000;
    localparam int          RSP_DEPTH = 2;
    localparam int          WORDS     = 1 << AW;
    localparam logic [31:0] WIN       = 32'(WORDS * 4);

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          csb;
    logic          web;
    logic [3:0]    wmask;
    logic [AW-1:0] saddr;
    logic [31:0]   din;
    logic [31:0]   dout = 32'h0;

    logic [31:0] sram_mem [WORDS];
    logic [31:0] ref_mem  [WORDS];
    exp_t        expq[$];

    int          total = 0;
    int          bad   = 0;
    logic        last_gnt;
    logic [31:0] last_rdata;
    logic        last_err;

    sram_obi_adapter_if bus ();

    sram_obi_adapter #(
        .SRAM_ADDR_WIDTH (AW),
        .BASE_ADDR       (BASE),
        .RSP_DEPTH       (RSP_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .sram_csb0_o   (csb),
        .sram_web0_o   (web),
        .sram_wmask0_o (wmask),
        .sram_addr0_o  (saddr),
        .sram_din0_o   (din),
        .sram_dout0_i  (dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro: one-cycle read latency, per-byte write mask.
    always @(posedge clk) begin
        if (!csb) begin
            if (!web) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) sram_mem[saddr][8*b +: 8] = din[8*b +: 8];
            end else begin
                dout <= sram_mem[saddr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, update the model, return just after the rising edge.
    task automatic tick();
        exp_t e;
        logic fire;
        logic gexp;
        logic inr;
        int   idx;
        @(negedge clk);
        last_gnt = 1'b0;
        if (rst) begin
            check("rst_gnt", 32'(bus.gnt_o), 0);
            check("rst_rvalid", 32'(bus.rvalid_o), 0);
            check("rst_csb", 32'(csb), 1);
            check("rst_web", 32'(web), 0);
            check("rst_addr", 32'(saddr), 0);
            expq.delete();
        end else begin
            fire = bus.rvalid_o && bus.rready_i;
            check("rvalid", 32'(bus.rvalid_o), 32'(expq.size() != 0));
            gexp = bus.req_i && ((expq.size() - int'(fire)) < RSP_DEPTH);
            check("gnt", 32'(bus.gnt_o), 32'(gexp));
            inr = (bus.addr_i >= BASE) && (bus.addr_i < BASE + WIN);
            check("csb", 32'(csb), 32'(!(bus.req_i && bus.gnt_o && inr)));
            if (fire && expq.size() > 0) begin
                e = expq.pop_front();
                check("rdata", bus.rdata_o, e.rdata);
                check("err", 32'(bus.err_o), 32'(e.err));
                last_rdata = bus.rdata_o;
                last_err   = bus.err_o;
            end
            if (bus.req_i && bus.gnt_o) begin
                last_gnt = 1'b1;
                if (inr) begin
                    idx = int'((bus.addr_i - BASE) / 4);
                    check("sram_addr", 32'(saddr), idx);
                    check("sram_web", 32'(web), 32'(!bus.we_i));
                    if (bus.we_i) begin
                        check("sram_wmask", 32'(wmask), 32'(bus.be_i));
                        check("sram_din", din, bus.wdata_i);
                        for (int b = 0; b < 4; b++)
                            if (bus.be_i[b]) ref_mem[idx][8*b +: 8] = bus.wdata_i[8*b +: 8];
                        e.rdata = 32'h0;
                    end else begin
                        e.rdata = ref_mem[idx];
                    end
                    e.err = 1'b0;
                end else begin
                    e.rdata = 32'h0;
                    e.err   = 1'b1;
                end
                expq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.be_i    = be;
        bus.wdata_i = wdata;
        last_gnt    = 1'b0;
        for (int i = 0; i < 30 && !last_gnt; i++) tick();
        check("req_granted", 32'(last_gnt), 1);
        bus.req_i = 1'b0;
    endtask

    task automatic drain();
        bus.req_i    = 1'b0;
        bus.rready_i = 1'b1;
        for (int i = 0; i < 40 && expq.size() > 0; i++) tick();
        check("drain", expq.size(), 0);
    endtask

    initial begin
        int n;
        int sel;
        for (int i = 0; i < WORDS; i++) begin
            sram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        bus.req_i    = 1'b1;
        bus.we_i     = 1'b0;
        bus.addr_i   = BASE;
        bus.be_i     = 4'hF;
        bus.wdata_i  = 32'h0;
        bus.rready_i = 1'b1;
        last_rdata   = 32'h0;
        last_err     = 1'b0;

        // Reset held with a pending request, then released.
        #1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("gnt_after_rst", 32'(last_gnt), 1);
        drain();

        // Full-word write then read-back, back to back.
        do_req(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
        do_req(1'b0, BASE + 32'h10, 4'h0, 32'h0);
        drain();
        check("wr_rd_full", last_rdata, 32'hDEAD_BEEF);

        // Single-byte partial write.
        do_req(1'b1, BASE + 32'h10, 4'b0010, 32'h0000_AB00);
        do_req(1'b0, BASE + 32'h12, 4'h0, 32'h0);
        drain();
        check("wr_rd_partial", last_rdata, 32'hDEAD_ABEF);

        // First byte past the window.
        do_req(1'b0, BASE + WIN, 4'h0, 32'h0);
        drain();
        check("oor_err", 32'(last_err), 1);
        check("oor_rdata", last_rdata, 0);

        // Backpressure: four reads with rready low, then released.
        for (int i = 0; i < 4; i++) do_req(1'b1, BASE + 32'h40 + 32'(4 * i), 4'hF, $urandom);
        drain();
        bus.rready_i = 1'b0;
        bus.req_i    = 1'b1;
        bus.we_i     = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            bus.addr_i = BASE + 32'h40 + 32'(4 * n);
            tick();
            if (last_gnt) n++;
        end
        check("grants_stalled", n, RSP_DEPTH);
        bus.rready_i = 1'b1;
        for (int i = 0; i < 20 && n < 4; i++) begin
            bus.addr_i = BASE + 32'h40 + 32'(4 * n);
            tick();
            if (last_gnt) n++;
        end
        check("grants_total", n, 4);
        drain();

        // Reset while two responses are pending.
        bus.rready_i = 1'b0;
        do_req(1'b0, BASE + 32'h40, 4'h0, 32'h0);
        do_req(1'b0, BASE + 32'h44, 4'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rready_i = 1'b1;
        tick();
        check("no_stale_rvalid", 32'(bus.rvalid_o), 0);
        do_req(1'b0, BASE + 32'h10, 4'h0, 32'h0);
        drain();
        check("rd_after_rst", last_rdata, 32'hDEAD_ABEF);

        // Randomized traffic with random backpressure and window boundaries.
        for (int i = 0; i < 500; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       bus.addr_i = BASE - 32'd4;
                1:       bus.addr_i = BASE + WIN;
                2:       bus.addr_i = BASE + WIN - 32'd4;
                3:       bus.addr_i = $urandom;
                default: bus.addr_i = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            endcase
            bus.req_i    = ($urandom_range(0, 3) != 0);
            bus.we_i     = $urandom_range(0, 1) == 1;
            bus.be_i     = 4'($urandom_range(0, 15));
            bus.wdata_i  = $urandom;
            bus.rready_i = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
